csoc_scan_ctrl: RTL and testbench
=================================

CSOC_SCAN_CTRL -- requirements
Module: csoc_scan_ctrl

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 4: clk cycles per csoc_clk phase, legal range 1..255.
REQ-002 SHALL have port clk, input, 1: single system clock; all flops on rising edge.
REQ-003 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1: host command present.
REQ-005 SHALL have port cmd_op, input, 2: command opcode. Values: 00 RSTPULSE, 01 SHIFT, 10 CAPTURE, 11 MODE.
REQ-006 SHALL have port cmd_arg, input, 8: command argument.
REQ-007 SHALL have port cmd_ready, output, 1: block can accept a command.
REQ-008 SHALL have port tx_data, output, 8: result byte sent to the UART transmitter.
REQ-009 SHALL have port new_tx_data, output, 1: one-cycle strobe that tx_data is valid.
REQ-010 SHALL have port tx_busy, input, 1: UART transmitter busy.
REQ-011 SHALL have ports csoc_clk, csoc_rstn, csoc_test_se and csoc_test_tm, each output, 1: CSoC test pins.
REQ-012 SHALL have port csoc_data_o, output, 8: byte driven to CSoC.
REQ-013 SHALL have port csoc_data_i, input, 8: byte sampled from CSoC.

Function
REQ-014 SHALL implement states IDLE, LOW, HIGH, DONE, SEND and WAIT_TX; cmd_ready is 1 only in IDLE.
REQ-015 SHALL accept a command on a clk edge where cmd_valid and cmd_ready are both 1; cmd_valid outside IDLE is ignored, not queued.
REQ-016 MODE: the acceptance edge SHALL set csoc_test_tm to cmd_arg[0], and the state SHALL stay IDLE, so cmd_ready remains 1.
REQ-017 RSTPULSE: on acceptance, csoc_rstn SHALL go to 0 and pulse count SHALL load cmd_arg+1, 9-bit, range 1..256; after the last pulse csoc_rstn SHALL go to 1.
REQ-018 SHIFT: on acceptance, csoc_test_se SHALL go to 1, csoc_data_o SHALL load cmd_arg, and pulse count SHALL be 1.
REQ-019 CAPTURE: on acceptance, csoc_test_se SHALL go to 0 and pulse count SHALL load cmd_arg+1.
REQ-020 Pulse generation: LOW SHALL hold csoc_clk=0 for exactly HALF_PERIOD cycles, then HIGH SHALL hold csoc_clk=1 for exactly HALF_PERIOD cycles; each LOW to HIGH pair is one pulse.
REQ-021 At the end of each HIGH phase, the pulse count SHALL decrement; if the result is nonzero the state SHALL go to LOW, else to DONE with csoc_clk=0. Period is 2*HALF_PERIOD with no gap between pulses.
REQ-022 SHIFT SHALL capture csoc_data_i into the result register on the clk edge that ends the HIGH phase.
REQ-023 DONE SHALL last 1 cycle and apply the end actions: RSTPULSE releases csoc_rstn; SHIFT clears csoc_test_se and goes to SEND; RSTPULSE and CAPTURE go to IDLE.
REQ-024 SEND SHALL wait while tx_busy=1; on the first cycle with tx_busy=0 it SHALL drive tx_data=result and new_tx_data=1 for exactly 1 cycle, then go to WAIT_TX.
REQ-025 WAIT_TX SHALL go to IDLE on the first cycle with tx_busy=0 after the strobe, so no back-to-back strobe can overrun the transmitter.
REQ-026 csoc_data_o SHALL hold its last value until the next SHIFT; csoc_test_tm SHALL change only on MODE or reset.
REQ-027 The phase counter SHALL be 8-bit and reload each phase; the pulse counter SHALL be 9-bit and never wrap, since its 256 maximum fits.

Reset
REQ-028 While rstn=0, asynchronously: state=IDLE, csoc_clk=0, csoc_rstn=0, csoc_test_se=0, csoc_test_tm=0, csoc_data_o=0, tx_data=0, new_tx_data=0, result=0, counters=0.
REQ-029 Reset mid-operation SHALL abort any command, including a pending tx strobe; csoc_rstn stays 0 until the next RSTPULSE completes.
REQ-030 After reset deasserts, cmd_ready SHALL be 1 on the first cycle.

Verification (HALF_PERIOD=4)
REQ-031 Check reset release, then RSTPULSE with arg=2 -> csoc_rstn=0 for 3 pulses (24 cycles), csoc_rstn=1 in DONE, cmd_ready=1 after 26 cycles.
REQ-032 Check SHIFT with arg=0xA5, csoc_data_i=0x3C, tx_busy=0 -> csoc_test_se=1 during one 8-cycle pulse, csoc_data_o=0xA5, one strobe with tx_data=0x3C, csoc_test_se=0 afterwards.
REQ-033 Check SHIFT with tx_busy held 1 for 20 cycles -> no strobe until tx_busy falls, exactly one strobe afterwards, and cmd_ready=0 throughout.
REQ-034 Check MODE with arg=0x01, then CAPTURE with arg=0xFF -> csoc_test_tm=1, exactly 256 csoc_clk rising edges with csoc_test_se=0, and no tx strobe.
REQ-035 Check cmd_valid during CAPTURE is ignored, and rstn pulsed low mid-CAPTURE -> all outputs at reset values immediately and cmd_ready=1 after release.

Source files
------------

// File: rtl/csoc_scan_ctrl.sv
// Scan/reset test controller for the CSoC: turns host commands into csoc_clk
// pulse trains on the test pins and returns SHIFT results to a UART transmitter.
module csoc_scan_ctrl #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_arg,
  output logic       cmd_ready,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  input  logic       tx_busy,
  output logic       csoc_clk,
  output logic       csoc_rstn,
  output logic       csoc_test_se,
  output logic       csoc_test_tm,
  output logic [7:0] csoc_data_o,
  input  logic [7:0] csoc_data_i
);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, DONE, SEND, WAIT_TX} state_t;
  typedef enum logic [1:0] {OP_RSTPULSE = 2'b00, OP_SHIFT = 2'b01,
                            OP_CAPTURE = 2'b10, OP_MODE = 2'b11} op_t;

  localparam logic [7:0] PH_LOAD = 8'(HALF_PERIOD - 1);

  state_t     state, state_d;
  op_t        op_q, op_d;
  logic [7:0] phase_cnt, phase_d;
  logic [8:0] pulse_cnt, pulse_d;
  logic [7:0] result, result_d;
  logic [7:0] tx_data_d, data_o_d;
  logic       new_tx_d, clk_d, rstn_d, se_d, tm_d;

  assign cmd_ready = (state == IDLE);

  always_comb begin
    state_d   = state;
    op_d      = op_q;
    phase_d   = phase_cnt;
    pulse_d   = pulse_cnt;
    result_d  = result;
    tx_data_d = tx_data;
    data_o_d  = csoc_data_o;
    new_tx_d  = 1'b0;
    clk_d     = csoc_clk;
    rstn_d    = csoc_rstn;
    se_d      = csoc_test_se;
    tm_d      = csoc_test_tm;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = op_t'(cmd_op);
          phase_d = PH_LOAD;
          case (op_t'(cmd_op))
            OP_MODE: tm_d = cmd_arg[0];
            OP_RSTPULSE: begin
              rstn_d  = 1'b0;
              pulse_d = {1'b0, cmd_arg} + 9'd1;
              state_d = LOW;
            end
            OP_SHIFT: begin
              se_d     = 1'b1;
              data_o_d = cmd_arg;
              pulse_d  = 9'd1;
              state_d  = LOW;
            end
            default: begin
              se_d    = 1'b0;
              pulse_d = {1'b0, cmd_arg} + 9'd1;
              state_d = LOW;
            end
          endcase
        end
      end
      LOW: begin
        if (phase_cnt == '0) begin
          clk_d   = 1'b1;
          phase_d = PH_LOAD;
          state_d = HIGH;
        end else begin
          phase_d = phase_cnt - 8'd1;
        end
      end
      HIGH: begin
        if (phase_cnt == '0) begin
          clk_d   = 1'b0;
          phase_d = PH_LOAD;
          pulse_d = pulse_cnt - 9'd1;
          if (op_q == OP_SHIFT) result_d = csoc_data_i;
          // End actions are registered on entry so they are visible during DONE
          if (pulse_cnt == 9'd1) begin
            phase_d = '0;
            state_d = DONE;
            if (op_q == OP_RSTPULSE) rstn_d = 1'b1;
            if (op_q == OP_SHIFT)    se_d   = 1'b0;
          end else begin
            state_d = LOW;
          end
        end else begin
          phase_d = phase_cnt - 8'd1;
        end
      end
      DONE: state_d = (op_q == OP_SHIFT) ? SEND : IDLE;
      SEND: begin
        if (!tx_busy) begin
          tx_data_d = result;
          new_tx_d  = 1'b1;
          state_d   = WAIT_TX;
        end
      end
      WAIT_TX: begin
        // Skip the strobe cycle itself: the transmitter raises busy one cycle later
        if (!new_tx_data && !tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      op_q         <= OP_RSTPULSE;
      phase_cnt    <= '0;
      pulse_cnt    <= '0;
      result       <= '0;
      tx_data      <= '0;
      new_tx_data  <= 1'b0;
      csoc_clk     <= 1'b0;
      csoc_rstn    <= 1'b0;
      csoc_test_se <= 1'b0;
      csoc_test_tm <= 1'b0;
      csoc_data_o  <= '0;
    end else begin
      state        <= state_d;
      op_q         <= op_d;
      phase_cnt    <= phase_d;
      pulse_cnt    <= pulse_d;
      result       <= result_d;
      tx_data      <= tx_data_d;
      new_tx_data  <= new_tx_d;
      csoc_clk     <= clk_d;
      csoc_rstn    <= rstn_d;
      csoc_test_se <= se_d;
      csoc_test_tm <= tm_d;
      csoc_data_o  <= data_o_d;
    end
  end

endmodule

// File: tb/tb_csoc_scan_ctrl.sv
// Randomised bench for csoc_scan_ctrl against a cycle-count reference model
// derived from the pulse-train and handshake rules.
module tb_csoc_scan_ctrl;

  localparam int HP = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       cmd_ready;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy;
  logic       csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm;
  logic [7:0] csoc_data_o, csoc_data_i;

  csoc_scan_ctrl #(.HALF_PERIOD(HP)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_ready(cmd_ready),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .csoc_clk(csoc_clk), .csoc_rstn(csoc_rstn), .csoc_test_se(csoc_test_se),
    .csoc_test_tm(csoc_test_tm), .csoc_data_o(csoc_data_o), .csoc_data_i(csoc_data_i)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state of the CSoC pins
  logic       m_rstn, m_se, m_tm;
  logic [7:0] m_dout, m_tx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] pins();
    return {cmd_ready, new_tx_data, csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_rstn = 1'b0; m_se = 1'b0; m_tm = 1'b0; m_dout = '0; m_tx = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk(tag, {pins(), csoc_data_o, tx_data}, {6'b100000, 8'h00, 8'h00});
  endtask

  // Assert reset mid-cycle, check values while asserted, release, expect ready
  task automatic async_abort();
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_reset_vals("abort_rst");
    cmd_valid = 1'b0;
    tx_busy   = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk("abort_ready", pins(), {1'b1, 1'b0, 1'b0, m_rstn, m_se, m_tm});
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] arg,
                         input int busy0, input int uart_len,
                         input int abort_at, input int abort_send,
                         input bit fixed_din, input logic [7:0] din);
    int         n;
    int         edges;
    int         busy_left;
    int         post;
    bit         pending, b, exp_strobe, exp_ready;
    logic       prev_clk;
    logic [7:0] cap;
    chk("ready_before", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    tx_busy   = 1'b0;
    step();
    cmd_valid = 1'b0;
    cap = '0;
    case (op)
      2'b11: begin
        m_tm = arg[0];
        chk("mode", pins(), {1'b1, 1'b0, 1'b0, m_rstn, m_se, m_tm});
        return;
      end
      2'b00: begin n = int'(arg) + 1; m_rstn = 1'b0; end
      2'b01: begin n = 1; m_se = 1'b1; m_dout = arg; end
      default: begin n = int'(arg) + 1; m_se = 1'b0; end
    endcase

    edges = 0;
    prev_clk = 1'b0;
    for (int k = 0; k < 2 * HP * n; k++) begin
      chk("pulse", pins(), {1'b0, 1'b0, 1'((k / HP) % 2), m_rstn, m_se, m_tm});
      chk("dout", csoc_data_o, m_dout);
      if (csoc_clk && !prev_clk) edges++;
      prev_clk = csoc_clk;
      if (k == abort_at) begin
        async_abort();
        return;
      end
      csoc_data_i = fixed_din ? din : 8'($urandom);
      if (k == 2 * HP - 1) cap = csoc_data_i;
      cmd_valid = (k < 2 * HP * n - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_op    = 2'($urandom);
      cmd_arg   = 8'($urandom);
      tx_busy   = 1'($urandom_range(0, 1));
      step();
    end
    cmd_valid = 1'b0;
    tx_busy   = 1'b0;
    chk("edges", edges, n);

    if (op == 2'b00) m_rstn = 1'b1;
    if (op == 2'b01) m_se = 1'b0;
    chk("done", pins(), {1'b0, 1'b0, 1'b0, m_rstn, m_se, m_tm});
    step();
    if (op != 2'b01) begin
      chk("idle", pins(), {1'b1, 1'b0, 1'b0, m_rstn, m_se, m_tm});
      return;
    end
    chk("send_entry", {cmd_ready, new_tx_data}, 2'b00);

    m_tx      = cap;
    busy_left = busy0;
    pending   = 1'b1;
    post      = 0;
    tx_busy   = (busy_left > 0);
    if (busy_left > 0) busy_left--;
    for (int it = 0; it < 400; it++) begin
      if (it == abort_send) begin
        async_abort();
        return;
      end
      b          = tx_busy;
      exp_strobe = pending && !b;
      exp_ready  = !pending && (post >= 1) && !b;
      step();
      chk("send", {cmd_ready, new_tx_data}, {exp_ready, exp_strobe});
      chk("pins_tx", {csoc_clk, csoc_rstn, csoc_test_se}, {1'b0, m_rstn, 1'b0});
      if (exp_strobe) begin
        chk("tx_data", tx_data, m_tx);
        pending   = 1'b0;
        post      = 0;
        busy_left = uart_len;
      end else if (!pending) begin
        post++;
      end
      if (exp_ready) begin
        tx_busy = 1'b0;
        return;
      end
      tx_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
    chk("send_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, arg, abort_at;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
    tx_busy = 1'b0; csoc_data_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("ready_release", cmd_ready, 1'b1);
    step();
    chk("ready_first", pins(), 6'b100000);

    run_cmd(2'b00, 8'd2,    0, 0, -1, -1, 1'b0, 8'h00);
    run_cmd(2'b01, 8'hA5,   0, 0, -1, -1, 1'b1, 8'h3C);
    run_cmd(2'b01, 8'h5A,  20, 3, -1, -1, 1'b1, 8'hC3);
    run_cmd(2'b11, 8'h01,   0, 0, -1, -1, 1'b0, 8'h00);
    run_cmd(2'b10, 8'hFF,   0, 0, -1, -1, 1'b0, 8'h00);
    run_cmd(2'b10, 8'h10,   0, 0, 37, -1, 1'b0, 8'h00);
    run_cmd(2'b01, 8'h77,  10, 2, -1,  4, 1'b0, 8'h00);

    for (int i = 0; i < 40; i++) begin
      op  = $urandom_range(0, 3);
      arg = ((op == 0 || op == 2) && $urandom_range(0, 7) != 0) ? $urandom_range(0, 20)
                                                                 : $urandom_range(0, 255);
      abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2 * HP - 1) : -1;
      run_cmd(2'(op), 8'(arg), $urandom_range(0, 6), $urandom_range(0, 4),
              abort_at, -1, 1'b0, 8'h00);
      repeat ($urandom_range(0, 2)) begin
        step();
        chk("idle_gap", pins(), {1'b1, 1'b0, 1'b0, m_rstn, m_se, m_tm});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
